// File: rtl/riscv_lsu_if.sv
// Data-memory request/ready bus between the load-store unit and memory.
// Signals:
//   req   - access request, held until ready
//   we    - 1 = store, 0 = load
//   be    - byte enables
//   addr  - byte address
//   wd    - lane-replicated store data
//   rd    - read data, valid while ready = 1
//   ready - access complete
// Modports: master (load-store unit), slave (memory).
interface riscv_lsu_if;
  logic        req;
  logic        we;
  logic [3:0]  be;
  logic [31:0] addr;
  logic [31:0] wd;
  logic [31:0] rd;
  logic        ready;

  modport master (output req, we, be, addr, wd, input rd, ready);
  modport slave  (input req, we, be, addr, wd, output rd, ready);
endinterface

// File: rtl/riscv_lsu.sv
// Load-store unit for the single-issue RISC-V core.
// Takes the decoder's request controls, the ALU-computed address and the rs2
// data. It issues the access on the data-memory bus and stalls the core until
// the access completes. It also formats store lanes and byte enables, and
// extends load data for writeback.
// Ports:
//   clk, rst        - clock, synchronous active-high reset
//   core_req/we     - access request, 1 = store
//   core_size       - 0 B, 1 H, 2 W, 4 BU, 5 HU
//   core_addr/wd    - byte address, store data
//   core_rd         - extended load data, valid in the completion cycle
//   core_stall      - hold PC and pipeline
//   access_fault    - misaligned address or unsupported size, nothing issued
//   bus_error       - one-cycle pulse when the memory times out
//   mem             - data-memory bus (master side)
module riscv_lsu #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               core_req,
  input  logic               core_we,
  input  logic [2:0]         core_size,
  input  logic [31:0]        core_addr,
  input  logic [31:0]        core_wd,
  output logic [31:0]        core_rd,
  output logic               core_stall,
  output logic               access_fault,
  output logic               bus_error,
  riscv_lsu_if.master        mem
);

  localparam int unsigned CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       addr_q, addr_d;
  logic [2:0]       size_q, size_d;
  logic             we_q, we_d;
  logic             fault_c;

  // Unsupported size codes fault regardless of address.
  function automatic logic size_bad(input logic [2:0] s, input logic [1:0] a);
    case (s)
      3'd0, 3'd4: size_bad = 1'b0;
      3'd1, 3'd5: size_bad = a[0];
      3'd2:       size_bad = (a != 2'b00);
      default:    size_bad = 1'b1;
    endcase
  endfunction

  function automatic logic [3:0] be_of(input logic [1:0] s, input logic [1:0] a);
    case (s)
      2'd0:    be_of = 4'b0001 << a;
      2'd1:    be_of = 4'b0011 << {a[1], 1'b0};
      default: be_of = 4'b1111;
    endcase
  endfunction

  function automatic logic [31:0] wd_of(input logic [1:0] s, input logic [31:0] wd);
    case (s)
      2'd0:    wd_of = {4{wd[7:0]}};
      2'd1:    wd_of = {2{wd[15:0]}};
      default: wd_of = wd;
    endcase
  endfunction

  // Lane extraction uses the latched low address bits.
  function automatic logic [31:0] rd_of(input logic [2:0] s, input logic [1:0] a,
                                        input logic [31:0] rd);
    logic [7:0]  b;
    logic [15:0] h;
    b = rd[{a, 3'b000} +: 8];
    h = a[1] ? rd[31:16] : rd[15:0];
    case (s)
      3'd0:    rd_of = {{24{b[7]}}, b};
      3'd4:    rd_of = {24'd0, b};
      3'd1:    rd_of = {{16{h[15]}}, h};
      3'd5:    rd_of = {16'd0, h};
      default: rd_of = rd;
    endcase
  endfunction

  assign fault_c = core_req && size_bad(core_size, core_addr[1:0]);

  // State and latched access attributes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      size_q  <= '0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
    end
  end

  // Next-state and bus/core outputs; everything is held quiet during reset.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    size_d       = size_q;
    we_d         = we_q;
    mem.req      = 1'b0;
    mem.we       = 1'b0;
    mem.be       = 4'b0000;
    mem.addr     = core_addr;
    mem.wd       = core_wd;
    core_rd      = 32'd0;
    core_stall   = 1'b0;
    access_fault = 1'b0;
    bus_error    = 1'b0;

    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          if (fault_c) begin
            access_fault = 1'b1;
          end else if (core_req) begin
            mem.req    = 1'b1;
            mem.we     = core_we;
            mem.be     = be_of(core_size[1:0], core_addr[1:0]);
            mem.wd     = wd_of(core_size[1:0], core_wd);
            core_stall = 1'b1;
            addr_d     = core_addr[1:0];
            size_d     = core_size;
            we_d       = core_we;
            cnt_d      = '0;
            state_d    = S_WAIT;
          end
        end
        S_WAIT: begin
          mem.req = 1'b1;
          mem.we  = we_q;
          mem.be  = be_of(size_q[1:0], addr_q);
          mem.wd  = wd_of(size_q[1:0], core_wd);
          // A ready arriving in the timeout cycle still completes the access.
          if (mem.ready) begin
            core_rd = rd_of(size_q, addr_q, mem.rd);
            state_d = S_IDLE;
          end else if ((TIMEOUT_CYCLES != 0) && (cnt_q == CNT_W'(TIMEOUT_CYCLES))) begin
            bus_error = 1'b1;
            cnt_d     = '0;
            state_d   = S_IDLE;
          end else begin
            core_stall = 1'b1;
            cnt_d      = cnt_q + CNT_W'(1);
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_riscv_lsu.sv
module tb_riscv_lsu;

  logic        clk;
  logic        rst;
  logic        core_req;
  logic        core_we;
  logic [2:0]  core_size;
  logic [31:0] core_addr;
  logic [31:0] core_wd;
  logic [31:0] core_rd;
  logic        core_stall;
  logic        access_fault;
  logic        bus_error;

  int n_checks;
  int n_fail;

  riscv_lsu_if mem_if ();

  riscv_lsu #(.TIMEOUT_CYCLES(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .core_req     (core_req),
    .core_we      (core_we),
    .core_size    (core_size),
    .core_addr    (core_addr),
    .core_wd      (core_wd),
    .core_rd      (core_rd),
    .core_stall   (core_stall),
    .access_fault (access_fault),
    .bus_error    (bus_error),
    .mem          (mem_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: access width in bytes, natural alignment, lane placement.
  function automatic bit m_fault(input logic [2:0] s, input logic [31:0] a);
    int n;
    if (s == 3 || s > 5) return 1'b1;
    n = 1 << s[1:0];
    return (a % n) != 0;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] s, input logic [31:0] a);
    int n;
    int off;
    n   = 1 << s[1:0];
    off = int'(a % 4) - int'(a % 4) % n;
    return 4'(((1 << n) - 1) << off);
  endfunction

  function automatic logic [31:0] m_wd(input logic [2:0] s, input logic [31:0] wd);
    int n;
    logic [31:0] r;
    n = 1 << s[1:0];
    for (int i = 0; i < 4; i++) r[8*i +: 8] = wd[8*(i % n) +: 8];
    return r;
  endfunction

  function automatic logic [31:0] m_rd(input logic [2:0] s, input logic [31:0] a,
                                       input logic [31:0] rd);
    int n;
    int off;
    logic [31:0] v;
    logic [31:0] mask;
    n    = 1 << s[1:0];
    off  = int'(a % 4) - int'(a % 4) % n;
    mask = (n == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * n)) - 32'd1);
    v    = (rd >> (8 * off)) & mask;
    if (!s[2] && n < 4 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic do_access(input string name, input logic we, input logic [2:0] s,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] rdata, input int delay);
    logic [3:0] ebe;
    core_req     = 1'b1;
    core_we      = we;
    core_size    = s;
    core_addr    = a;
    core_wd      = wd;
    mem_if.ready = 1'($urandom_range(0, 1));
    mem_if.rd    = $urandom;
    @(negedge clk);
    if (m_fault(s, a)) begin
      n_checks++;
      if ({access_fault, mem_if.req, core_stall, bus_error} !== 4'b1000) begin
        n_fail++;
        $display("FAIL %s fault: fault/req/stall/berr got %b want 1000", name,
                 {access_fault, mem_if.req, core_stall, bus_error});
      end
      @(posedge clk); #1;
      core_req     = 1'b0;
      mem_if.ready = 1'b0;
      return;
    end
    ebe = m_be(s, a);
    n_checks++;
    if ({access_fault, mem_if.req, core_stall, mem_if.we, mem_if.be} !== {3'b011, we, ebe}) begin
      n_fail++;
      $display("FAIL %s issue: fault/req/stall/we/be got %b want %b", name,
               {access_fault, mem_if.req, core_stall, mem_if.we, mem_if.be}, {3'b011, we, ebe});
    end
    n_checks++;
    if ({mem_if.addr, core_rd} !== {a, 32'd0}) begin
      n_fail++;
      $display("FAIL %s issue addr/rd: got %h/%h want %h/0", name, mem_if.addr, core_rd, a);
    end
    if (we) begin
      n_checks++;
      if (mem_if.wd !== m_wd(s, wd)) begin
        n_fail++;
        $display("FAIL %s issue wd: got %h want %h", name, mem_if.wd, m_wd(s, wd));
      end
    end
    @(posedge clk); #1;
    for (int k = 0; k < delay; k++) begin
      mem_if.ready = 1'b0;
      mem_if.rd    = $urandom;
      @(negedge clk);
      n_checks++;
      if ({mem_if.req, core_stall, mem_if.we, mem_if.be, access_fault, bus_error, mem_if.addr, core_rd}
          !== {2'b11, we, ebe, 2'b00, a, 32'd0}) begin
        n_fail++;
        $display("FAIL %s wait: req/stall/we/be/flt/berr got %b addr %h rd %h want %b addr %h rd 0",
                 name, {mem_if.req, core_stall, mem_if.we, mem_if.be, access_fault, bus_error},
                 mem_if.addr, core_rd, {2'b11, we, ebe, 2'b00}, a);
      end
      if (we) begin
        n_checks++;
        if (mem_if.wd !== m_wd(s, wd)) begin
          n_fail++;
          $display("FAIL %s wait wd: got %h want %h", name, mem_if.wd, m_wd(s, wd));
        end
      end
      @(posedge clk); #1;
    end
    mem_if.ready = 1'b1;
    mem_if.rd    = rdata;
    @(negedge clk);
    n_checks++;
    if ({mem_if.req, core_stall, mem_if.we, mem_if.be, bus_error} !== {2'b10, we, ebe, 1'b0}) begin
      n_fail++;
      $display("FAIL %s done: req/stall/we/be/berr got %b want %b", name,
               {mem_if.req, core_stall, mem_if.we, mem_if.be, bus_error}, {2'b10, we, ebe, 1'b0});
    end
    n_checks++;
    if (we) begin
      if (mem_if.wd !== m_wd(s, wd)) begin
        n_fail++;
        $display("FAIL %s done wd: got %h want %h", name, mem_if.wd, m_wd(s, wd));
      end
    end else if (core_rd !== m_rd(s, a, rdata)) begin
      n_fail++;
      $display("FAIL %s done rd: got %h want %h", name, core_rd, m_rd(s, a, rdata));
    end
    @(posedge clk); #1;
    core_req     = 1'b0;
    mem_if.ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      core_req     = 1'b1;
      core_we      = 1'($urandom_range(0, 1));
      core_size    = 3'($urandom_range(0, 7));
      core_addr    = $urandom;
      core_wd      = $urandom;
      mem_if.ready = 1'b1;
      mem_if.rd    = $urandom;
      @(negedge clk);
      n_checks++;
      if ({mem_if.req, mem_if.we, core_stall, access_fault, bus_error, core_rd} !== 37'd0) begin
        n_fail++;
        $display("FAIL reset: req/we/stall/flt/berr got %b rd %h want 00000 rd 0",
                 {mem_if.req, mem_if.we, core_stall, access_fault, bus_error}, core_rd);
      end
      @(posedge clk); #1;
    end
    rst          = 1'b0;
    core_req     = 1'b0;
    mem_if.ready = 1'b0;
  endtask

  task automatic test_idle();
    for (int i = 0; i < 4; i++) begin
      core_req     = 1'b0;
      core_we      = 1'b1;
      core_size    = 3'd2;
      core_addr    = $urandom;
      core_wd      = $urandom;
      mem_if.ready = 1'($urandom_range(0, 1));
      mem_if.rd    = $urandom;
      @(negedge clk);
      n_checks++;
      if ({mem_if.req, mem_if.we, mem_if.be, core_stall, access_fault, bus_error,
           mem_if.addr, mem_if.wd, core_rd} !== {9'd0, core_addr, core_wd, 32'd0}) begin
        n_fail++;
        $display("FAIL idle: ctl %b addr %h wd %h rd %h want ctl 0 addr %h wd %h rd 0",
                 {mem_if.req, mem_if.we, mem_if.be, core_stall, access_fault, bus_error},
                 mem_if.addr, mem_if.wd, core_rd, core_addr, core_wd);
      end
      @(posedge clk); #1;
    end
    mem_if.ready = 1'b0;
  endtask

  task automatic test_directed();
    do_access("lw_100",  1'b0, 3'd2, 32'h0000_0100, 32'h0,          32'hDEAD_BEEF, 0);
    do_access("lb_103",  1'b0, 3'd0, 32'h0000_0103, 32'h0,          32'h80FF_1234, 1);
    do_access("lbu_103", 1'b0, 3'd4, 32'h0000_0103, 32'h0,          32'h80FF_1234, 0);
    do_access("lh_102",  1'b0, 3'd1, 32'h0000_0102, 32'h0,          32'h80FF_1234, 0);
    do_access("lhu_102", 1'b0, 3'd5, 32'h0000_0102, 32'h0,          32'h80FF_1234, 0);
    do_access("sh_102",  1'b1, 3'd1, 32'h0000_0102, 32'h0000_ABCD,  32'h0,         2);
    do_access("sb_101",  1'b1, 3'd0, 32'h0000_0101, 32'h1234_56A5,  32'h0,         1);
  endtask

  task automatic test_fault();
    do_access("lw_101",  1'b0, 3'd2, 32'h0000_0101, 32'h0, 32'h0, 0);
    do_access("sz3_100", 1'b0, 3'd3, 32'h0000_0100, 32'h0, 32'h0, 0);
    do_access("sh_103",  1'b1, 3'd1, 32'h0000_0103, 32'h0, 32'h0, 0);
    do_access("sz7_100", 1'b1, 3'd7, 32'h0000_0100, 32'h0, 32'h0, 0);
  endtask

  task automatic test_timeout();
    int first;
    int pulses;
    logic stall_at;
    logic [31:0] rd_at;
    first        = -1;
    pulses       = 0;
    stall_at     = 1'b1;
    rd_at        = 32'hFFFF_FFFF;
    core_req     = 1'b1;
    core_we      = 1'b0;
    core_size    = 3'd2;
    core_addr    = 32'h0000_0200;
    core_wd      = 32'h0;
    mem_if.ready = 1'b0;
    mem_if.rd    = 32'hCAFE_F00D;
    @(negedge clk);
    n_checks++;
    if ({mem_if.req, core_stall} !== 2'b11) begin
      n_fail++;
      $display("FAIL timeout issue: req/stall got %b want 11", {mem_if.req, core_stall});
    end
    @(posedge clk); #1;
    for (int i = 1; i <= 12; i++) begin
      @(negedge clk);
      if (bus_error) begin
        pulses++;
        if (first < 0) begin
          first    = i;
          stall_at = core_stall;
          rd_at    = core_rd;
        end
      end
      @(posedge clk); #1;
      if (first >= 0) core_req = 1'b0;
    end
    n_checks++;
    if (first != 5) begin
      n_fail++;
      $display("FAIL timeout cycle: got %0d want 5", first);
    end
    n_checks++;
    if (pulses != 1) begin
      n_fail++;
      $display("FAIL timeout pulses: got %0d want 1", pulses);
    end
    n_checks++;
    if ({stall_at, rd_at} !== 33'd0) begin
      n_fail++;
      $display("FAIL timeout release: stall %b rd %h want 0/0", stall_at, rd_at);
    end
    do_access("after_to", 1'b0, 3'd1, 32'h0000_0206, 32'h0, 32'h0000_7FFE, 1);
  endtask

  task automatic test_reset_mid();
    core_req     = 1'b1;
    core_we      = 1'b0;
    core_size    = 3'd2;
    core_addr    = 32'h0000_0300;
    core_wd      = 32'h0;
    mem_if.ready = 1'b0;
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({mem_if.req, core_stall, access_fault, bus_error} !== 4'b0000) begin
      n_fail++;
      $display("FAIL rst_mid: req/stall/flt/berr got %b want 0000",
               {mem_if.req, core_stall, access_fault, bus_error});
    end
    @(posedge clk); #1;
    rst          = 1'b0;
    core_req     = 1'b0;
    mem_if.ready = 1'b1;
    mem_if.rd    = 32'h5555_AAAA;
    @(negedge clk);
    n_checks++;
    if ({mem_if.req, core_stall, core_rd} !== 34'd0) begin
      n_fail++;
      $display("FAIL rst_late_ready: req/stall %b rd %h want 00 rd 0", {mem_if.req, core_stall}, core_rd);
    end
    @(posedge clk); #1;
    mem_if.ready = 1'b0;
    do_access("lw_after_rst", 1'b0, 3'd2, 32'h0000_0304, 32'h0, 32'h1234_5678, 1);
  endtask

  task automatic test_back_to_back();
    do_access("b2b_0", 1'b0, 3'd2, 32'h0000_0400, 32'h0,         32'h0102_0304, 0);
    do_access("b2b_1", 1'b1, 3'd0, 32'h0000_0402, 32'h0000_00EE, 32'h0,         0);
    do_access("b2b_2", 1'b0, 3'd5, 32'h0000_0402, 32'h0,         32'hF00D_8001, 0);
    do_access("b2b_3", 1'b1, 3'd2, 32'h0000_0404, 32'h89AB_CDEF, 32'h0,         0);
  endtask

  task automatic test_random();
    logic [2:0] sizes [5];
    logic [2:0] s;
    logic [2:0] bad [3];
    sizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
    bad   = '{3'd3, 3'd6, 3'd7};
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) s = bad[$urandom_range(0, 2)];
      else s = sizes[$urandom_range(0, 4)];
      do_access("rand", 1'($urandom_range(0, 1)), s, $urandom, $urandom, $urandom,
                int'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        @(posedge clk); #1;
      end
    end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    core_req     = 1'b0;
    core_we      = 1'b0;
    core_size    = 3'd0;
    core_addr    = 32'h0;
    core_wd      = 32'h0;
    mem_if.ready = 1'b0;
    mem_if.rd    = 32'h0;
    @(posedge clk); #1;
    test_reset();
    test_idle();
    test_directed();
    test_fault();
    test_timeout();
    test_reset_mid();
    test_back_to_back();
    test_random();
    test_idle();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
